// File: rtl/fir_cfg_master_if.sv
// AXI-Lite bus between fir_cfg_master (initiator) and the fir accelerator (target).
// The write response channel is not part of this bus.
interface fir_cfg_master_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/fir_cfg_master.sv
// AXI-Lite initiator that checks ap_idle, programs data_length and taps, starts the fir and polls
// for ap_done. Define CFG_READBACK_EN to read back and verify every tap before ap_start.
module fir_cfg_master #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned POLL_MAX    = 4096
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  output logic [3:0]             tap_idx,
  input  logic [pDATA_WIDTH-1:0] tap_coef,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  fir_cfg_master_if.master       bus
);

  localparam int unsigned PollW = $clog2(POLL_MAX + 1);
  localparam int unsigned GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [pADDR_WIDTH-1:0] AddrCtrl = '0;
  localparam logic [pADDR_WIDTH-1:0] AddrLen  = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] AddrTap  = pADDR_WIDTH'(32'h20);
  localparam logic [3:0]             TapLast  = 4'(Tape_Num - 1);
  localparam logic [PollW-1:0]       PollLast = PollW'(POLL_MAX - 1);
  localparam logic [GapW-1:0]        GapLast  = GapW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    StIdle,
    StChkIdle,
    StWrLen,
    StWrTap,
`ifdef CFG_READBACK_EN
    StRdTap,
`endif
    StWrAp,
    StPollRd,
    StPollWait,
    StFin
  } state_e;

  state_e r_state, w_state_nxt;

  logic                   r_awvalid, r_wvalid, r_arvalid, r_rready;
  logic                   r_aw_done, r_w_done, r_act, r_err;
  logic [pADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [pDATA_WIDTH-1:0] r_wdata;
  logic [31:0]            r_len;
  logic [3:0]             r_tap_idx;
  logic [PollW-1:0]       r_poll_cnt;
  logic [GapW-1:0]        r_gap_cnt;

  logic                   w_aw_hs, w_w_hs, w_rd_hs, w_wr_cpl, w_rd_cpl;
  logic                   w_is_wr, w_is_rd, w_tap_last;
  logic [pADDR_WIDTH-1:0] w_addr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic                   w_unused_rdata;

  assign w_aw_hs    = r_awvalid & bus.awready;
  assign w_w_hs     = r_wvalid & bus.wready;
  assign w_rd_hs    = r_rready & bus.rvalid;
  assign w_tap_last = (r_tap_idx == TapLast);
  // A write finishes once both channels have handshaken, in either order or together.
  assign w_wr_cpl   = r_act & w_is_wr & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_rd_cpl   = r_act & w_is_rd & w_rd_hs;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= StIdle;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_is_wr     = 1'b0;
    w_is_rd     = 1'b0;
    w_addr      = AddrCtrl;
    w_data      = '0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (cfg_start) w_state_nxt = StChkIdle;
      end
      StChkIdle: begin
        w_is_rd = 1'b1;
        if (w_rd_cpl) w_state_nxt = bus.rdata[2] ? StWrLen : StFin;
      end
      StWrLen: begin
        w_is_wr = 1'b1;
        w_addr  = AddrLen;
        w_data  = pDATA_WIDTH'(r_len);
        if (w_wr_cpl) w_state_nxt = StWrTap;
      end
      StWrTap: begin
        w_is_wr = 1'b1;
        w_addr  = AddrTap + pADDR_WIDTH'({r_tap_idx, 2'b00});
        w_data  = tap_coef;
`ifdef CFG_READBACK_EN
        if (w_wr_cpl && w_tap_last) w_state_nxt = StRdTap;
`else
        if (w_wr_cpl && w_tap_last) w_state_nxt = StWrAp;
`endif
      end
`ifdef CFG_READBACK_EN
      StRdTap: begin
        w_is_rd = 1'b1;
        w_addr  = AddrTap + pADDR_WIDTH'({r_tap_idx, 2'b00});
        if (w_rd_cpl && w_tap_last) w_state_nxt = StWrAp;
      end
`endif
      StWrAp: begin
        w_is_wr = 1'b1;
        w_data  = pDATA_WIDTH'(1);
        if (w_wr_cpl) w_state_nxt = StPollRd;
      end
      StPollRd: begin
        w_is_rd = 1'b1;
        if (w_rd_cpl) begin
          w_state_nxt = (bus.rdata[1] || (r_poll_cnt == PollLast)) ? StFin : StPollWait;
        end
      end
      StPollWait: begin
        if (r_gap_cnt == GapLast) w_state_nxt = StPollRd;
      end
      StFin: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = StIdle;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Bus channel registers; a new transaction is only issued when none is in flight.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_act     <= 1'b0;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (r_arvalid && bus.arready) r_arvalid <= 1'b0;
      if (w_rd_hs) r_rready <= 1'b0;

      if (w_wr_cpl || w_rd_cpl) begin
        r_act <= 1'b0;
      end else if (!r_act && w_is_wr) begin
        r_act     <= 1'b1;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_awaddr  <= w_addr;
        r_wdata   <= w_data;
      end else if (!r_act && w_is_rd) begin
        r_act     <= 1'b1;
        r_arvalid <= 1'b1;
        r_rready  <= 1'b1;
        r_araddr  <= w_addr;
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_err      <= 1'b0;
      r_len      <= '0;
      r_tap_idx  <= '0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state == StIdle && cfg_start) begin
        r_err <= 1'b0;
        r_len <= cfg_len;
      end
      if (r_state == StChkIdle && w_rd_cpl && !bus.rdata[2]) r_err <= 1'b1;
      if (r_state == StPollRd && w_rd_cpl && !bus.rdata[1] && r_poll_cnt == PollLast) begin
        r_err <= 1'b1;
      end
`ifdef CFG_READBACK_EN
      if (r_state == StRdTap && w_rd_cpl && bus.rdata != tap_coef) r_err <= 1'b1;
      if ((r_state == StWrTap && w_wr_cpl) || (r_state == StRdTap && w_rd_cpl)) begin
        r_tap_idx <= w_tap_last ? 4'd0 : r_tap_idx + 4'd1;
      end
`else
      if (r_state == StWrTap && w_wr_cpl) begin
        r_tap_idx <= w_tap_last ? 4'd0 : r_tap_idx + 4'd1;
      end
`endif
      if (r_state == StWrAp) begin
        r_poll_cnt <= '0;
      end else if (r_state == StPollRd && w_rd_cpl) begin
        r_poll_cnt <= r_poll_cnt + PollW'(1);
      end
      r_gap_cnt <= (r_state == StPollWait) ? r_gap_cnt + GapW'(1) : '0;
    end
  end

  assign bus.awvalid    = r_awvalid;
  assign bus.awaddr     = r_awaddr;
  assign bus.wvalid     = r_wvalid;
  assign bus.wdata      = r_wdata;
  assign bus.arvalid    = r_arvalid;
  assign bus.araddr     = r_araddr;
  assign bus.rready     = r_rready;
  assign tap_idx        = r_tap_idx;
  assign err            = r_err;
  assign w_unused_rdata = ^bus.rdata;

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed bench for fir_cfg_master with a behavioural AXI-Lite fir target that logs traffic.
module tb_fir_cfg_master;
  localparam int unsigned PollMax = 16;
  localparam int unsigned PollGap = 4;

  logic        axis_clk   = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        cfg_start  = 1'b0;
  logic [31:0] cfg_len    = 32'd0;
  logic [3:0]  tap_idx;
  logic [31:0] tap_coef;
  logic        busy, done, err;

  fir_cfg_master_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) bus ();

  fir_cfg_master #(
    .pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11), .POLL_GAP(PollGap), .POLL_MAX(PollMax)
  ) dut (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .tap_idx   (tap_idx),
    .tap_coef  (tap_coef),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 axis_clk = ~axis_clk;

  int coef_tab [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  assign tap_coef = (tap_idx < 4'd11) ? 32'(coef_tab[tap_idx]) : 32'd0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  // Target knobs (written by tests only)
  int          aw_delay   = 0;
  int          w_delay    = 0;
  int          done_after = 0;  // 0: never report ap_done
  int          bad_tap    = -1;
  logic [31:0] bad_val    = 32'd0;
  bit          idle_knob  = 1'b1;

  // Target state and logs (written by the target model only)
  bit          aw_got, w_got, rd_pend, started;
  int          aw_cnt, w_cnt, poll_cnt, viol;
  logic [11:0] aw_lat, ar_lat;
  logic [31:0] w_lat;
  logic [31:0] tap_mem [11];
  logic [11:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [11:0] rd_addr_q [$];
  int          rd_cyc_q  [$];

  initial begin : target_model
    int k;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    forever begin
      @(negedge axis_clk);
      if (!axis_rst_n) begin
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'd0;
        aw_got = 0; w_got = 0; rd_pend = 0; started = 0;
        aw_cnt = 0; w_cnt = 0; poll_cnt = 0; viol = 0;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
        foreach (tap_mem[i]) tap_mem[i] = 32'd0;
      end else begin
        if ((bus.awvalid || bus.wvalid) && (bus.arvalid || bus.rready)) viol++;
        if (bus.awready) bus.awready = 1'b0;
        else if (bus.awvalid) begin
          if (aw_got) viol++;
          else if (aw_cnt >= aw_delay) begin
            bus.awready = 1'b1; aw_lat = bus.awaddr; aw_got = 1; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (bus.wready) bus.wready = 1'b0;
        else if (bus.wvalid) begin
          if (w_got) viol++;
          else if (w_cnt >= w_delay) begin
            bus.wready = 1'b1; w_lat = bus.wdata; w_got = 1; w_cnt = 0;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin
          wr_addr_q.push_back(aw_lat);
          wr_data_q.push_back(w_lat);
          if (aw_lat == 12'h000 && w_lat[0]) started = 1;
          if (aw_lat >= 12'h020 && aw_lat <= 12'h048) tap_mem[(int'(aw_lat) - 32) / 4] = w_lat;
          aw_got = 0;
          w_got  = 0;
        end
        if (bus.rvalid) bus.rvalid = 1'b0;
        else if (rd_pend) begin
          if (!bus.rready) viol++;
          bus.rvalid = 1'b1;
          rd_pend    = 0;
          if (ar_lat == 12'h000) begin
            if (started) poll_cnt++;
            bus.rdata = {29'd0, (idle_knob && !started),
                         (started && done_after != 0 && poll_cnt >= done_after), 1'b0};
          end else if (ar_lat >= 12'h020 && ar_lat <= 12'h048) begin
            k = (int'(ar_lat) - 32) / 4;
            bus.rdata = (k == bad_tap) ? bad_val : tap_mem[k];
          end else bus.rdata = 32'd0;
        end
        if (bus.arready) bus.arready = 1'b0;
        else if (bus.arvalid) begin
          bus.arready = 1'b1;
          ar_lat      = bus.araddr;
          rd_pend     = 1;
          rd_addr_q.push_back(bus.araddr);
          rd_cyc_q.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] exp_addr(int i);
    if (i == 0) return 12'h010;
    if (i <= 11) return 12'(32 + 4 * (i - 1));
    return 12'h000;
  endfunction

  function automatic logic [31:0] exp_data(int i, logic [31:0] len);
    if (i == 0) return len;
    if (i <= 11) return 32'(coef_tab[i - 1]);
    return 32'd1;
  endfunction

  task automatic do_reset();
    axis_rst_n = 1'b0;
    cfg_start  = 1'b0;
    repeat (2) @(negedge axis_clk);
    #2 axis_rst_n = 1'b1;
    @(negedge axis_clk);
  endtask

  task automatic pulse_start(input logic [31:0] len);
    @(negedge axis_clk);
    cfg_len   = len;
    cfg_start = 1'b1;
    @(negedge axis_clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge axis_clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready} !== 4'b0) begin
      bad++;
      $display("FAIL reset_valids: got %b want 0000",
               {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready});
    end
    total++;
    if ({busy, done, err} !== 3'b0) begin
      bad++; $display("FAIL reset_status: got %b want 000", {busy, done, err});
    end
    total++;
    if ({tap_idx, bus.awaddr, bus.araddr, bus.wdata} !== 60'd0) begin
      bad++;
      $display("FAIL reset_regs: got idx=%0d aw=%h ar=%h wd=%h want all 0",
               tap_idx, bus.awaddr, bus.araddr, bus.wdata);
    end
  endtask

  task automatic test_normal();
    bit seen;
    int n;
    do_reset();
    idle_knob = 1; done_after = 3; aw_delay = 0; w_delay = 0; bad_tap = -1;
    pulse_start(32'd600);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL norm_busy: got %b want 1", busy); end
    wait_done(500, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL norm_done: got no done pulse want pulse"); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL norm_err: got %b want 0", err); end
    @(negedge axis_clk);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL norm_after: got done,busy=%b want 00", {done, busy});
    end
    total++;
    if (wr_addr_q.size() != 13) begin
      bad++; $display("FAIL norm_wr_count: got %0d want 13", wr_addr_q.size());
    end
    for (int i = 0; i < 13; i++) begin
      logic [11:0] ga;
      logic [31:0] gd;
      ga = (i < wr_addr_q.size()) ? wr_addr_q[i] : 12'hfff;
      gd = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hdeadbeef;
      total++;
      if (ga !== exp_addr(i) || gd !== exp_data(i, 32'd600)) begin
        bad++;
        $display("FAIL norm_wr%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, ga, gd, exp_addr(i), exp_data(i, 32'd600));
      end
    end
    n = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] >= 12'h020 && rd_addr_q[i] <= 12'h048) n++;
`ifndef CFG_READBACK_EN
    total++;
    if (n != 0) begin bad++; $display("FAIL norm_tap_reads: got %0d want 0", n); end
    total++;
    if (rd_addr_q.size() != 4) begin
      bad++; $display("FAIL norm_rd_count: got %0d want 4", rd_addr_q.size());
    end
`endif
    total++;
    if (viol != 0) begin bad++; $display("FAIL norm_overlap: got %0d want 0", viol); end
  endtask

  task automatic test_aw_stall();
    bit seen;
    do_reset();
    idle_knob = 1; done_after = 1; aw_delay = 3; w_delay = 0; bad_tap = -1;
    pulse_start(32'd600);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge axis_clk);
      if (bus.awvalid) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_aw_rise: got no awvalid want awvalid"); end
    @(negedge axis_clk);
    total++;
    if ({bus.awvalid, bus.wvalid} !== 2'b10) begin
      bad++; $display("FAIL stall_w_first: got aw,w=%b want 10", {bus.awvalid, bus.wvalid});
    end
    pulse_start(32'd7);  // must be ignored while busy
    wait_done(1000, seen);
    total++;
    if (!seen || err !== 1'b0) begin
      bad++; $display("FAIL stall_done: got seen=%b err=%b want 1 0", seen, err);
    end
    total++;
    if (wr_addr_q.size() != 13) begin
      bad++; $display("FAIL stall_wr_count: got %0d want 13", wr_addr_q.size());
    end
    for (int i = 0; i < 13; i++) begin
      logic [11:0] ga;
      logic [31:0] gd;
      ga = (i < wr_addr_q.size()) ? wr_addr_q[i] : 12'hfff;
      gd = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hdeadbeef;
      total++;
      if (ga !== exp_addr(i) || gd !== exp_data(i, 32'd600)) begin
        bad++;
        $display("FAIL stall_wr%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, ga, gd, exp_addr(i), exp_data(i, 32'd600));
      end
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL stall_overlap: got %0d want 0", viol); end
    aw_delay = 0;
  endtask

  task automatic test_not_idle();
    bit seen;
    do_reset();
    idle_knob = 0; done_after = 1; bad_tap = -1;
    pulse_start(32'd600);
    wait_done(200, seen);
    total++;
    if (!seen || err !== 1'b1) begin
      bad++; $display("FAIL notidle_done: got seen=%b err=%b want 1 1", seen, err);
    end
    total++;
    if (wr_addr_q.size() != 0 || rd_addr_q.size() != 1) begin
      bad++;
      $display("FAIL notidle_traffic: got wr=%0d rd=%0d want 0 1",
               wr_addr_q.size(), rd_addr_q.size());
    end
    idle_knob = 1;
  endtask

  task automatic test_poll_timeout();
    bit seen;
    int nz;
    int gap_bad;
    do_reset();
    idle_knob = 1; done_after = 0; bad_tap = -1;
    pulse_start(32'd600);
    wait_done(int'(PollMax) * 20 + 500, seen);
    total++;
    if (!seen || err !== 1'b1) begin
      bad++; $display("FAIL timeout_done: got seen=%b err=%b want 1 1", seen, err);
    end
    nz = 0;
    foreach (rd_addr_q[i]) if (i > 0 && rd_addr_q[i] == 12'h000) nz++;
    total++;
    if (nz != int'(PollMax) || rd_addr_q.size() != int'(PollMax) + 1) begin
      bad++;
      $display("FAIL timeout_polls: got %0d of %0d reads want %0d",
               nz, rd_addr_q.size() - 1, PollMax);
    end
    gap_bad = 0;
    for (int i = 2; i < rd_cyc_q.size(); i++) begin
      if (rd_cyc_q[i] - rd_cyc_q[i-1] <= int'(PollGap) ||
          rd_cyc_q[i] - rd_cyc_q[i-1] != rd_cyc_q[2] - rd_cyc_q[1]) gap_bad++;
    end
    total++;
    if (gap_bad != 0) begin
      bad++; $display("FAIL timeout_spacing: got %0d uneven or short gaps want 0", gap_bad);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    idle_knob = 1; done_after = 2; bad_tap = -1;
    pulse_start(32'd600);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge axis_clk);
      if (bus.awvalid && bus.awaddr == 12'h034) begin seen = 1; break; end
    end
    total++;
    if (!seen || tap_idx !== 4'd5) begin
      bad++; $display("FAIL mid_reach_tap5: got seen=%b idx=%0d want 1 5", seen, tap_idx);
    end
    #2 axis_rst_n = 1'b0;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.rready, busy, done, err} !== 7'b0 ||
        tap_idx !== 4'd0) begin
      bad++;
      $display("FAIL mid_async_clear: got v=%b st=%b idx=%0d want 0",
               {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, {busy, done, err}, tap_idx);
    end
    repeat (2) @(negedge axis_clk);
    #2 axis_rst_n = 1'b1;
    pulse_start(32'd600);
    total++;
    if ({busy, err} !== 2'b10) begin
      bad++; $display("FAIL mid_restart: got busy,err=%b want 10", {busy, err});
    end
    wait_done(500, seen);
    total++;
    if (!seen || err !== 1'b0) begin
      bad++; $display("FAIL mid_done: got seen=%b err=%b want 1 0", seen, err);
    end
    total++;
    if (rd_addr_q.size() == 0 || rd_addr_q[0] !== 12'h000 || wr_addr_q.size() != 13 ||
        wr_addr_q[0] !== 12'h010) begin
      bad++;
      $display("FAIL mid_sequence: got rd=%0d wr=%0d want first rd 0x000 then 13 writes",
               rd_addr_q.size(), wr_addr_q.size());
    end
  endtask

`ifdef CFG_READBACK_EN
  task automatic test_readback();
    bit seen;
    int n;
    do_reset();
    idle_knob = 1; done_after = 1; bad_tap = 3; bad_val = 32'd24;
    pulse_start(32'd600);
    wait_done(800, seen);
    total++;
    if (!seen || err !== 1'b1) begin
      bad++; $display("FAIL rb_done: got seen=%b err=%b want 1 1", seen, err);
    end
    n = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] >= 12'h020 && rd_addr_q[i] <= 12'h048) n++;
    total++;
    if (n != 11) begin bad++; $display("FAIL rb_tap_reads: got %0d want 11", n); end
    total++;
    if (wr_addr_q.size() != 13 || wr_addr_q[wr_addr_q.size()-1] !== 12'h000 ||
        wr_data_q[wr_data_q.size()-1] !== 32'd1) begin
      bad++; $display("FAIL rb_ap_start: got %0d writes want 13 ending 0x000<=1", wr_addr_q.size());
    end
    bad_tap = -1;
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_aw_stall();
    test_not_idle();
    test_poll_timeout();
    test_reset_mid();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
